// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: schedule sizing, scheduler state encoding and the
// small sigma/choice/majority helpers used by the schedule and round stages.
package sha256_pkg;

  localparam int unsigned NUM_WORDS  = 16;
  localparam int unsigned NUM_ROUNDS = 64;
  localparam int unsigned ADDR_W     = $clog2(NUM_WORDS);
  localparam int unsigned ROUND_W    = $clog2(NUM_ROUNDS);

  typedef enum logic [2:0] {
    StIdle,
    StFetchReq,
    StFetchWait,
    StEmit,
    StDone
  } msg_sched_state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] big_sig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/msg_scheduler_if.sv
// Bundle of the scheduler's control, word-fetch and schedule-output handshakes.
// master is the scheduler side; slave is the controller/compression-core side.
interface msg_scheduler_if;
  import sha256_pkg::*;

  logic                 start;
  logic                 busy;
  logic                 done;
  logic [ADDR_W-1:0]    word_address;
  logic                 req_word;
  logic [31:0]          word_data;
  logic                 word_valid;
  logic                 w_valid;
  logic                 w_ready;
  logic [31:0]          w_data;
  logic [ROUND_W-1:0]   w_round;

  modport master (
    input  start, word_data, word_valid, w_ready,
    output busy, done, word_address, req_word, w_valid, w_data, w_round
  );

  modport slave (
    output start, word_data, word_valid, w_ready,
    input  busy, done, word_address, req_word, w_valid, w_data, w_round
  );

endinterface

// File: rtl/msg_scheduler.sv
// SHA-256 message schedule: fetches 16 words of a block, then streams W[0..63]
// from a 16-entry sliding window, computing W[t+16] as each W[t] is accepted.
module msg_scheduler
  import sha256_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  msg_scheduler_if.master  bus
);

  msg_sched_state_t     state_q;
  logic                 busy_q;
  logic                 req_q;
  logic                 w_valid_q;
  logic                 done_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [ROUND_W-1:0]   round_q;
  logic [31:0]          win_q [NUM_WORDS];

  logic                 handshake;
  logic [31:0]          w_next;

  assign handshake = w_valid_q & bus.w_ready;

  // win_q[0] holds W[t]; the new tail entry is W[t+16].
  assign w_next = ssig1(win_q[NUM_WORDS-2]) + win_q[NUM_WORDS-7]
                + ssig0(win_q[1]) + win_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      req_q     <= 1'b0;
      w_valid_q <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      round_q   <= '0;
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StFetchReq;
            busy_q  <= 1'b1;
            addr_q  <= '0;
            round_q <= '0;
          end
        end

        StFetchReq: begin
          req_q   <= 1'b1;
          state_q <= StFetchWait;
        end

        // Dropping req_q here and re-raising it from StFetchReq leaves exactly
        // one low cycle between consecutive word requests.
        StFetchWait: begin
          if (bus.word_valid) begin
            win_q[addr_q] <= bus.word_data;
            req_q         <= 1'b0;
            if (addr_q == ADDR_W'(NUM_WORDS - 1)) begin
              state_q   <= StEmit;
              w_valid_q <= 1'b1;
              round_q   <= '0;
            end else begin
              addr_q  <= addr_q + 1'b1;
              state_q <= StFetchReq;
            end
          end
        end

        StEmit: begin
          if (handshake) begin
            for (int unsigned i = 0; i < NUM_WORDS - 1; i++) begin
              win_q[i] <= win_q[i+1];
            end
            win_q[NUM_WORDS-1] <= w_next;
            if (round_q == ROUND_W'(NUM_ROUNDS - 1)) begin
              w_valid_q <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= StDone;
            end else begin
              round_q <= round_q + 1'b1;
            end
          end
        end

        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.req_word     = req_q;
  assign bus.word_address = addr_q;
  assign bus.w_valid      = w_valid_q;
  assign bus.w_data       = win_q[0];
  assign bus.w_round      = round_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_msg_scheduler.sv
// Self-checking bench for msg_scheduler: a word-serving controller model, a
// compression-core consumer and an array-based SHA-256 schedule reference.
module tb_msg_scheduler;

  logic clk;
  logic rst_n;

  msg_scheduler_if bus ();

  msg_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          round;
    logic [31:0] w;
  } vec_t;

  int          checks;
  int          failures;
  logic [31:0] blk   [16];
  logic [31:0] w_exp [64];
  logic [31:0] got_w [64];
  int          exp_t;
  int          served_q [$];
  int          max_delay;
  int          ready_mode;
  bit          garbage_en;
  vec_t        vecs  [8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  // W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], over the whole array.
  function automatic void build_model();
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) w_exp[t] = blk[t];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w_exp[t-15], 7) ^ ror(w_exp[t-15], 18) ^ (w_exp[t-15] >> 3);
      s1 = ror(w_exp[t-2], 17) ^ ror(w_exp[t-2], 19) ^ (w_exp[t-2] >> 10);
      w_exp[t] = s1 + w_exp[t-7] + s0 + w_exp[t-16];
    end
  endfunction

  // Controller model: serves each request after a random delay.
  initial begin
    int          cnt;
    int          gap;
    logic [3:0]  last_addr;
    cnt = -1;
    gap = 0;
    last_addr = '0;
    bus.word_valid = 1'b0;
    bus.word_data  = '0;
    forever begin
      @(negedge clk);
      bus.word_valid = 1'b0;
      bus.word_data  = '0;
      if (!rst_n) begin
        cnt = -1;
        gap = 0;
      end else begin
        if (gap == 1) begin
          chk("req_gap_low", 32'(bus.req_word), 32'd0);
          gap = (last_addr != 4'd15) ? 2 : 0;
        end else if (gap == 2) begin
          chk("req_reassert", 32'(bus.req_word), 32'd1);
          gap = 0;
        end
        if (bus.req_word) begin
          if (cnt < 0) cnt = int'($urandom_range(max_delay, 0));
          if (cnt == 0) begin
            bus.word_valid = 1'b1;
            bus.word_data  = blk[bus.word_address];
            served_q.push_back(int'(bus.word_address));
            last_addr = bus.word_address;
            gap = 1;
            cnt = -1;
          end else begin
            cnt--;
          end
        end else begin
          if (cnt >= 0) chk("req_held", 32'(bus.req_word), 32'd1);
          cnt = -1;
          if (garbage_en) begin
            bus.word_valid = 1'b1;
            bus.word_data  = $urandom;
          end
        end
      end
    end
  end

  // Compression-core model: drives w_ready and checks every offered W_t.
  initial begin
    logic r;
    r = 1'b0;
    bus.w_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_t = 0;
        r = 1'b0;
        bus.w_ready = 1'b0;
      end else begin
        case (ready_mode)
          0:       r = 1'b1;
          1:       r = ~r;
          default: r = 1'($urandom_range(1, 0));
        endcase
        bus.w_ready = r;
        if (bus.w_valid) begin
          if (exp_t >= 64) begin
            chk("w_extra", 32'(exp_t), 32'd63);
          end else begin
            chk("w_round", 32'(bus.w_round), 32'(exp_t));
            chk("w_data", bus.w_data, w_exp[exp_t]);
            if (r) begin
              got_w[exp_t] = bus.w_data;
              exp_t++;
            end
          end
        end
      end
    end
  end

  task automatic load_block(input bit abc);
    for (int i = 0; i < 16; i++) blk[i] = abc ? 32'h0 : $urandom;
    if (abc) begin
      blk[0]  = 32'h61626380;
      blk[15] = 32'h00000018;
    end
    build_model();
    exp_t = 0;
    served_q.delete();
    for (int i = 0; i < 64; i++) got_w[i] = '0;
  endtask

  // Called at posedge+2; start is seen by the DUT on the next edge.
  task automatic start_block(input bit abc);
    load_block(abc);
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
  endtask

  task automatic finish_block();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(posedge clk); #2;
      if (bus.done) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("w_count", 32'(exp_t), 32'd64);
    chk("done_w_valid", 32'(bus.w_valid), 32'd0);
    chk("done_busy", 32'(bus.busy), 32'd1);
    chk("addr_count", 32'(served_q.size()), 32'd16);
    for (int i = 0; i < served_q.size() && i < 16; i++) begin
      chk("addr_order", 32'(served_q[i]), 32'(i));
    end
    @(posedge clk); #2;
    chk("done_pulse_len", 32'(bus.done), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_abc_table();
    for (int i = 0; i < 8; i++) begin
      chk("abc_vec", got_w[vecs[i].round], vecs[i].w);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_req", 32'(bus.req_word), 32'd0);
    chk("rst_w_valid", 32'(bus.w_valid), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_addr", 32'(bus.word_address), 32'd0);
    chk("rst_round", 32'(bus.w_round), 32'd0);
    chk("rst_w_data", bus.w_data, 32'd0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    max_delay  = 0;
    ready_mode = 0;
    garbage_en = 1'b0;
    exp_t      = 0;
    bus.start  = 1'b0;
    rst_n      = 1'b0;

    vecs[0] = '{0,  32'h61626380};
    vecs[1] = '{1,  32'h00000000};
    vecs[2] = '{14, 32'h00000000};
    vecs[3] = '{15, 32'h00000018};
    vecs[4] = '{16, 32'h61626380};
    vecs[5] = '{17, 32'h000F0000};
    vecs[6] = '{18, 32'h7DA86405};
    vecs[7] = '{2,  32'h00000000};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    #1;
    rst_n = 1'b1;
    @(posedge clk); #2;
    check_reset_outputs();

    // abc block, always ready
    start_block(1'b1);
    finish_block();
    check_abc_table();

    // abc block, ready toggling every cycle
    ready_mode = 1;
    start_block(1'b1);
    finish_block();
    check_abc_table();

    // random blocks, random fetch latency and backpressure
    max_delay  = 5;
    ready_mode = 2;
    for (int b = 0; b < 3; b++) begin
      start_block(1'b0);
      finish_block();
    end

    // start pulses mid-fetch and mid-emit are ignored; restart right after done
    start_block(1'b0);
    for (int i = 0; i < 200 && !bus.req_word; i++) begin @(posedge clk); #2; end
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    for (int i = 0; i < 500 && !bus.w_valid; i++) begin @(posedge clk); #2; end
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    finish_block();
    start_block(1'b0);
    finish_block();
    repeat (4) begin @(posedge clk); #2; end
    chk("no_stray_block", 32'(bus.busy), 32'd0);

    // reset at t=30, then rerun abc
    max_delay  = 0;
    ready_mode = 0;
    start_block(1'b1);
    for (int i = 0; i < 500 && exp_t < 30; i++) begin @(posedge clk); #2; end
    chk("reach_t30", 32'(exp_t), 32'd30);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) begin @(posedge clk); #2; end
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    start_block(1'b1);
    finish_block();
    check_abc_table();

    // garbage word_valid in IDLE, fetch gaps and EMIT
    garbage_en = 1'b1;
    max_delay  = 3;
    ready_mode = 2;
    repeat (5) begin @(posedge clk); #2; end
    chk("garbage_idle_busy", 32'(bus.busy), 32'd0);
    start_block(1'b0);
    finish_block();
    repeat (3) begin @(posedge clk); #2; end
    chk("garbage_after_busy", 32'(bus.busy), 32'd0);
    garbage_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
